// File: rtl/bomb_pkg.sv
// Shared types and width helpers for the bomb controller.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package bomb_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_ARM      = 4'd1,
    S_RUN      = 4'd2,
    S_PAUSE    = 4'd3,
    S_RESUME   = 4'd4,
    S_LAMP_ON  = 4'd5,
    S_LAMP_OFF = 4'd6,
    S_DONE     = 4'd7,
    S_DEFUSED  = 4'd8
  } bomb_state_t;

  // Width needed to count resume ticks from 0 up to resume_sec inclusive.
  function automatic int lat_cnt_w(input int resume_sec);
    int w;
    w = $clog2(resume_sec + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Width needed to count completed blinks from 0 up to blinks; never below 1 bit.
  function automatic int blink_cnt_w(input int blinks);
    int w;
    w = $clog2(blinks + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bomb_down_counter.sv
// Loadable saturating down counter for the countdown seconds.
// Latency: value updates one clock after load or an enabled tick.
// Backpressure: none; load wins over tick, decrement stops at zero.
module bomb_down_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  input  logic             en,
  input  logic             tick,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] value_q;
  logic [CNT_W-1:0] value_d;

  // Next value: reload, or decrement on an enabled tick without wrapping below zero.
  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = loadVal;
    end else if (en && tick && (value_q != '0)) begin
      value_d = value_q - CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign zero  = (value_q == '0);

endmodule

// File: rtl/bomb_ctrl_gen2.sv
// Bomb controller: arm/run countdown, pause with resume latency, defuse, bounded explosion blink.
// Latency: Moore outputs follow the registered state; one clock from input to state change.
// Backpressure: none; optional low-time warning output enabled by defining BOMB_WARN_EN.
module bomb_ctrl_gen2
  import bomb_pkg::*;
#(
  parameter int CNT_W       = 4,
  parameter int RESUME_SEC  = 1,
  parameter int BLINKS      = 5,
  parameter int WARN_THRESH = 3
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic             waitN,
  input  logic             defuseN,
  input  logic             OneSecPulse,
  input  logic             duty50,
  input  logic [CNT_W-1:0] loadValue,
  output logic [CNT_W-1:0] countValue,
  output logic             lampEnable,
  output logic             lampTest,
  output logic             running,
  output logic             exploded,
  output logic             defused,
  output logic             warn
);

  localparam int LAT_W = lat_cnt_w(RESUME_SEC);
  localparam int BLK_W = blink_cnt_w(BLINKS);

  bomb_state_t      state_q;
  bomb_state_t      state_d;
  logic [LAT_W-1:0] lat_cnt_q;
  logic [LAT_W-1:0] lat_cnt_d;
  logic [BLK_W-1:0] blink_cnt_q;
  logic [BLK_W-1:0] blink_cnt_d;
  logic [LAT_W-1:0] lat_inc;
  logic [BLK_W-1:0] blink_inc;
  logic             cnt_zero;

  // Countdown is reloaded on every ARM clock and only ticks while running.
  bomb_down_counter #(
    .CNT_W (CNT_W)
  ) u_down_counter (
    .clk     (clk),
    .resetN  (resetN),
    .load    (state_q == S_ARM),
    .loadVal (loadValue),
    .en      (state_q == S_RUN),
    .tick    (OneSecPulse),
    .value   (countValue),
    .zero    (cnt_zero)
  );

  assign lat_inc   = lat_cnt_q + LAT_W'(1);
  assign blink_inc = blink_cnt_q + BLK_W'(1);

  // Next-state logic; explosion on a zero count outranks defuse, which outranks pause.
  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    blink_cnt_d = blink_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (!start) state_d = S_ARM;
      end
      S_ARM: begin
        lat_cnt_d   = '0;
        blink_cnt_d = '0;
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (cnt_zero) begin
          state_d = S_LAMP_ON;
        end else if (!defuseN) begin
          state_d = S_DEFUSED;
        end else if (!waitN) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        lat_cnt_d = '0;
        if (!defuseN) begin
          state_d = S_DEFUSED;
        end else if (waitN && OneSecPulse) begin
          if (RESUME_SEC == 1) begin
            state_d = S_RUN;
          end else begin
            state_d   = S_RESUME;
            lat_cnt_d = LAT_W'(1);
          end
        end
      end
      S_RESUME: begin
        if (!defuseN) begin
          state_d = S_DEFUSED;
        end else if (!waitN) begin
          state_d   = S_PAUSE;
          lat_cnt_d = '0;
        end else if (OneSecPulse) begin
          lat_cnt_d = lat_inc;
          if (lat_inc == LAT_W'(RESUME_SEC)) state_d = S_RUN;
        end
      end
      S_LAMP_ON: begin
        if (!duty50) state_d = S_LAMP_OFF;
      end
      S_LAMP_OFF: begin
        if (duty50) begin
          blink_cnt_d = blink_inc;
          // BLINKS of zero never terminates; the counter just wraps harmlessly.
          if ((BLINKS != 0) && (blink_inc == BLK_W'(BLINKS))) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LAMP_ON;
          end
        end
      end
      S_DONE: begin
        if (!start) state_d = S_ARM;
      end
      S_DEFUSED: begin
        if (!start) state_d = S_ARM;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and latency/blink counter registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= S_IDLE;
      lat_cnt_q   <= '0;
      blink_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  // Moore decode from the registered state so outputs drop the instant reset asserts.
  assign running    = (state_q == S_RUN);
  assign lampTest   = (state_q == S_LAMP_ON);
  assign defused    = (state_q == S_DEFUSED);
  assign exploded   = (state_q == S_LAMP_ON) || (state_q == S_LAMP_OFF) || (state_q == S_DONE);
  assign lampEnable = (state_q == S_RUN) || (state_q == S_PAUSE) || (state_q == S_RESUME) ||
                      (state_q == S_LAMP_ON) || (state_q == S_DEFUSED);

`ifdef BOMB_WARN_EN
  assign warn = running && (countValue <= CNT_W'(WARN_THRESH)) && (countValue != '0) && duty50;
`else
  // Threshold is an elaboration constant here, so this folds to a constant 0.
  assign warn = 1'b0 & (WARN_THRESH != 0);
`endif

endmodule

// File: tb/tb_bomb_ctrl_gen2.sv
// Self-checking bench for bomb_ctrl_gen2: directed scenarios plus a randomized run.
// Latency: outputs sampled 1ns after the rising edge.
// Backpressure: n/a.
module tb_bomb_ctrl_gen2;

  localparam int CNT_W       = 4;
  localparam int RESUME_SEC  = 2;
  localparam int BLINKS      = 2;
  localparam int WARN_THRESH = 3;

`ifdef BOMB_WARN_EN
  localparam bit WARN_ON = 1'b1;
`else
  localparam bit WARN_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             resetN;
  logic             start;
  logic             waitN;
  logic             defuseN;
  logic             OneSecPulse;
  logic             duty50;
  logic [CNT_W-1:0] loadValue;
  logic [CNT_W-1:0] countValue;
  logic             lampEnable;
  logic             lampTest;
  logic             running;
  logic             exploded;
  logic             defused;
  logic             warn;
  logic [4:0]       outs5;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign outs5 = {lampEnable, lampTest, running, exploded, defused};

  bomb_ctrl_gen2 #(
    .CNT_W       (CNT_W),
    .RESUME_SEC  (RESUME_SEC),
    .BLINKS      (BLINKS),
    .WARN_THRESH (WARN_THRESH)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .start       (start),
    .waitN       (waitN),
    .defuseN     (defuseN),
    .OneSecPulse (OneSecPulse),
    .duty50      (duty50),
    .loadValue   (loadValue),
    .countValue  (countValue),
    .lampEnable  (lampEnable),
    .lampTest    (lampTest),
    .running     (running),
    .exploded    (exploded),
    .defused     (defused),
    .warn        (warn)
  );

  // ---------------- behavioural reference model ----------------
  typedef enum {PH_IDLE, PH_ARMED, PH_COUNT, PH_HOLD, PH_RESUMING,
                PH_FLASH_ON, PH_FLASH_OFF, PH_FINISHED, PH_SAFE} ph_t;
  ph_t m_ph;
  int  m_cnt;
  int  m_lat;
  int  m_blk;

  function automatic void m_reset();
    m_ph  = PH_IDLE;
    m_cnt = 0;
    m_lat = 0;
    m_blk = 0;
  endfunction

  // Advance the model by one clock using the inputs the DUT sees at that edge.
  function automatic void m_step();
    ph_t nx;
    bit  was_zero;
    nx = m_ph;
    case (m_ph)
      PH_IDLE:  if (!start) nx = PH_ARMED;
      PH_ARMED: begin
        m_cnt = int'(loadValue);
        m_blk = 0;
        if (start) nx = PH_COUNT;
      end
      PH_COUNT: begin
        was_zero = (m_cnt == 0);
        if (OneSecPulse && m_cnt > 0) m_cnt = m_cnt - 1;
        if (was_zero) nx = PH_FLASH_ON;
        else if (!defuseN) nx = PH_SAFE;
        else if (!waitN) nx = PH_HOLD;
      end
      PH_HOLD: begin
        if (!defuseN) nx = PH_SAFE;
        else if (waitN && OneSecPulse) begin
          if (RESUME_SEC == 1) nx = PH_COUNT;
          else begin
            nx    = PH_RESUMING;
            m_lat = 1;
          end
        end
      end
      PH_RESUMING: begin
        if (!defuseN) nx = PH_SAFE;
        else if (!waitN) nx = PH_HOLD;
        else if (OneSecPulse) begin
          m_lat = m_lat + 1;
          if (m_lat == RESUME_SEC) nx = PH_COUNT;
        end
      end
      PH_FLASH_ON:  if (!duty50) nx = PH_FLASH_OFF;
      PH_FLASH_OFF: begin
        if (duty50) begin
          m_blk = m_blk + 1;
          nx = (BLINKS != 0 && m_blk == BLINKS) ? PH_FINISHED : PH_FLASH_ON;
        end
      end
      PH_FINISHED: if (!start) nx = PH_ARMED;
      PH_SAFE:     if (!start) nx = PH_ARMED;
      default:     nx = PH_IDLE;
    endcase
    m_ph = nx;
  endfunction

  function automatic logic [4:0] m_outs5();
    logic le, lt, rn, ex, df;
    le = (m_ph inside {PH_COUNT, PH_HOLD, PH_RESUMING, PH_FLASH_ON, PH_SAFE});
    lt = (m_ph == PH_FLASH_ON);
    rn = (m_ph == PH_COUNT);
    ex = (m_ph inside {PH_FLASH_ON, PH_FLASH_OFF, PH_FINISHED});
    df = (m_ph == PH_SAFE);
    return {le, lt, rn, ex, df};
  endfunction

  function automatic logic m_warn();
    return WARN_ON && (m_ph == PH_COUNT) && (m_cnt >= 1) && (m_cnt <= WARN_THRESH) && duty50;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse1();
    OneSecPulse = 1'b1;
    clk1();
    OneSecPulse = 1'b0;
    clk1();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    resetN = 1'b0; start = 1'b1; waitN = 1'b1; defuseN = 1'b1;
    OneSecPulse = 1'b0; duty50 = 1'b0; loadValue = '0;
    #12;
    checks++;
    if (outs5 !== 5'b00000 || warn !== 1'b0) begin
      failures++; $display("FAIL reset_outs: got %b/%b want 00000/0", outs5, warn);
    end
    checks++;
    if (countValue !== '0) begin
      failures++; $display("FAIL reset_count: got %0d want 0", countValue);
    end
    resetN = 1'b1;
    clk1();
    checks++;
    if (outs5 !== 5'b00000) begin
      failures++; $display("FAIL idle_after_reset: got %b want 00000", outs5);
    end
  endtask

  task automatic test_explode();
    int phases;
    logic prev;
    start = 1'b0; clk1();
    loadValue = 4'd3; clk1();
    checks++;
    if (countValue !== 4'd3 || outs5 !== 5'b00000) begin
      failures++; $display("FAIL arm_load: got %0d/%b want 3/00000", countValue, outs5);
    end
    start = 1'b1; clk1();
    checks++;
    if (outs5 !== 5'b10100 || countValue !== 4'd3) begin
      failures++; $display("FAIL run_entry: got %b/%0d want 10100/3", outs5, countValue);
    end
    duty50 = 1'b1;
    for (int i = 2; i >= 0; i--) begin
      OneSecPulse = 1'b1; clk1(); OneSecPulse = 1'b0;
      checks++;
      if (countValue !== CNT_W'(i) || running !== 1'b1) begin
        failures++; $display("FAIL countdown: got %0d run=%b want %0d run=1", countValue, running, i);
      end
      clk1();
    end
    checks++;
    if (outs5 !== 5'b11010) begin
      failures++; $display("FAIL lamp_on_after_zero: got %b want 11010", outs5);
    end
    phases = 1;
    prev   = 1'b1;
    for (int c = 0; c < 24; c++) begin
      duty50 = ((c / 2) % 2) != 0;
      clk1();
      if (lampTest && !prev) phases++;
      prev = lampTest;
    end
    checks++;
    if (phases !== BLINKS) begin
      failures++; $display("FAIL blink_phases: got %0d want %0d", phases, BLINKS);
    end
    checks++;
    if (outs5 !== 5'b00010) begin
      failures++; $display("FAIL done_outs: got %b want 00010", outs5);
    end
    defuseN = 1'b0; waitN = 1'b0; clk1();
    checks++;
    if (outs5 !== 5'b00010) begin
      failures++; $display("FAIL done_ignores_inputs: got %b want 00010", outs5);
    end
    defuseN = 1'b1; waitN = 1'b1;
  endtask

  task automatic test_pause();
    start = 1'b0; clk1();
    loadValue = 4'd6; clk1();
    start = 1'b1; clk1();
    OneSecPulse = 1'b1; clk1(); OneSecPulse = 1'b0;
    waitN = 1'b0; clk1();
    checks++;
    if (outs5 !== 5'b10000 || countValue !== 4'd5) begin
      failures++; $display("FAIL pause_entry: got %b/%0d want 10000/5", outs5, countValue);
    end
    waitN = 1'b1; clk1();
    pulse1();
    checks++;
    if (outs5 !== 5'b10000) begin
      failures++; $display("FAIL resume_needs_two: got %b want 10000", outs5);
    end
    waitN = 1'b0; clk1();
    waitN = 1'b1; clk1();
    pulse1();
    checks++;
    if (outs5 !== 5'b10000 || countValue !== 4'd5) begin
      failures++; $display("FAIL repause_restart: got %b/%0d want 10000/5", outs5, countValue);
    end
    pulse1();
    checks++;
    if (outs5 !== 5'b10100 || countValue !== 4'd5) begin
      failures++; $display("FAIL resumed_run: got %b/%0d want 10100/5", outs5, countValue);
    end
    pulse1();
    checks++;
    if (countValue !== 4'd4) begin
      failures++; $display("FAIL decrement_after_resume: got %0d want 4", countValue);
    end
  endtask

  task automatic test_defuse();
    defuseN = 1'b0; clk1(); defuseN = 1'b1;
    checks++;
    if (outs5 !== 5'b10001 || countValue !== 4'd4) begin
      failures++; $display("FAIL defuse_entry: got %b/%0d want 10001/4", outs5, countValue);
    end
    repeat (10) pulse1();
    checks++;
    if (outs5 !== 5'b10001 || countValue !== 4'd4) begin
      failures++; $display("FAIL defuse_frozen: got %b/%0d want 10001/4", outs5, countValue);
    end
    loadValue = 4'd9; start = 1'b0; clk1(); clk1();
    checks++;
    if (outs5 !== 5'b00000 || countValue !== 4'd9) begin
      failures++; $display("FAIL defuse_rearm: got %b/%0d want 00000/9", outs5, countValue);
    end
  endtask

  task automatic test_simultaneous();
    loadValue = 4'd1; clk1();
    start = 1'b1; clk1();
    duty50 = 1'b1;
    OneSecPulse = 1'b1; clk1(); OneSecPulse = 1'b0;
    defuseN = 1'b0; waitN = 1'b0; clk1();
    checks++;
    if (outs5 !== 5'b11010) begin
      failures++; $display("FAIL zero_beats_defuse: got %b want 11010", outs5);
    end
    defuseN = 1'b1; waitN = 1'b1;
  endtask

  task automatic test_zero_reset();
    resetN = 1'b0; #3; resetN = 1'b1;
    start = 1'b0; loadValue = 4'd0; duty50 = 1'b1; clk1(); clk1();
    start = 1'b1; clk1();
    checks++;
    if (outs5 !== 5'b10100 || countValue !== 4'd0) begin
      failures++; $display("FAIL zero_load_run: got %b/%0d want 10100/0", outs5, countValue);
    end
    clk1();
    checks++;
    if (outs5 !== 5'b11010) begin
      failures++; $display("FAIL zero_load_explode: got %b want 11010", outs5);
    end
    #2; resetN = 1'b0; #1;
    checks++;
    if (outs5 !== 5'b00000 || warn !== 1'b0 || countValue !== 4'd0) begin
      failures++; $display("FAIL async_reset: got %b/%b/%0d want 00000/0/0", outs5, warn, countValue);
    end
    #1; resetN = 1'b1; clk1();
    checks++;
    if (outs5 !== 5'b00000) begin
      failures++; $display("FAIL idle_after_async: got %b want 00000", outs5);
    end
  endtask

  task automatic test_warn();
    loadValue = 4'd4; start = 1'b0; clk1(); clk1();
    start = 1'b1; clk1();
    duty50 = 1'b1; #1;
    checks++;
    if (warn !== 1'b0) begin
      failures++; $display("FAIL warn_above_thresh: got %b want 0", warn);
    end
    for (int k = 3; k >= 0; k--) begin
      OneSecPulse = 1'b1; clk1(); OneSecPulse = 1'b0;
      for (int d = 0; d < 2; d++) begin
        duty50 = d[0]; #1;
        checks++;
        if (warn !== (WARN_ON && k != 0 && d == 1)) begin
          failures++; $display("FAIL warn_count%0d_duty%0d: got %b want %b", k, d, warn,
                               (WARN_ON && k != 0 && d == 1));
        end
      end
    end
    clk1();
    checks++;
    if (warn !== 1'b0 || lampTest !== 1'b1) begin
      failures++; $display("FAIL warn_outside_run: got %b/%b want 0/1", warn, lampTest);
    end
  endtask

  task automatic test_random();
    resetN = 1'b0; #3; resetN = 1'b1;
    m_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        resetN = 1'b0; #1;
        m_reset();
        checks++;
        if (outs5 !== 5'b00000 || countValue !== '0) begin
          failures++; $display("FAIL rand_reset n=%0d: got %b/%0d want 00000/0", n, outs5, countValue);
        end
        resetN = 1'b1;
      end
      start       = ($urandom_range(0, 99) >= 8);
      waitN       = ($urandom_range(0, 99) >= 4);
      defuseN     = ($urandom_range(0, 99) >= 2);
      OneSecPulse = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 3) == 0) duty50 = ~duty50;
      loadValue   = CNT_W'($urandom_range(0, 9));
      m_step();
      clk1();
      checks++;
      if (countValue !== CNT_W'(m_cnt)) begin
        failures++; $display("FAIL rand_count n=%0d: got %0d want %0d", n, countValue, m_cnt);
      end
      checks++;
      if (outs5 !== m_outs5() || warn !== m_warn()) begin
        failures++; $display("FAIL rand_outs n=%0d: got %b/%b want %b/%b", n, outs5, warn,
                             m_outs5(), m_warn());
      end
    end
  endtask

  initial begin
    test_reset();
    test_explode();
    test_pause();
    test_defuse();
    test_simultaneous();
    test_zero_reset();
    test_warn();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bomb_ctrl_gen2.md
Name: bomb_ctrl_gen2

Overview:
Second-generation bomb controller for the lab top level. It integrates the countdown timer and has a parametrised count width, a multi-second resume latency and a bounded explosion blink sequence. It also adds a defuse path with terminal states. It drives the lamp/7-seg logic and gets its time base from the existing one-second pulse and 50%-duty blink generators.

Parameters:
CNT_W, 4, width of countdown value (seconds)
RESUME_SEC, 1, consecutive OneSecPulse ticks with waitN high needed to resume from pause (>=1)
BLINKS, 5, number of lamp on/off cycles before DONE; 0 = blink forever
WARN_THRESH, 3, warning threshold in seconds (used only with BOMB_WARN_EN)

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
start  in  1  active-low push button: press arms, release runs
waitN  in  1  active-low pause request
defuseN  in  1  active-low defuse button
OneSecPulse  in  1  one-clock pulse per second
duty50  in  1  blink square wave
loadValue  in  CNT_W  initial countdown value
countValue  out  CNT_W  current remaining seconds
lampEnable  out  1  lamp driver enable
lampTest  out  1  lamp forced on
running  out  1  high in S_RUN only
exploded  out  1  high in S_LAMP_ON, S_LAMP_OFF, S_DONE
defused  out  1  high in S_DEFUSED
warn  out  1  low-time warning (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset resetN is asynchronous and active-low. Reset forces S_IDLE, countValue=0, latency counter=0, blink counter=0. All outputs are low after reset.
- Moore outputs decode from the registered state. Next-state logic is combinational.
- State S_IDLE: lamp off. start==0 -> S_ARM.
- State S_ARM: countValue<=loadValue every clock, lamp off. start==1 -> S_RUN.
- State S_RUN: lampEnable=1, running=1. On OneSecPulse, countValue decrements by 1 and saturates at 0. Transition priority:
  - countValue==0 -> S_LAMP_ON
  - else defuseN==0 -> S_DEFUSED
  - else waitN==0 -> S_PAUSE
  - loadValue=0 therefore explodes 1 clock after entering S_RUN.
- State S_PAUSE: countValue frozen, lampEnable=1. latCnt cleared. waitN==1 && OneSecPulse -> S_RESUME with latCnt=1. If RESUME_SEC==1, go directly to S_RUN instead. defuseN==0 -> S_DEFUSED, with priority over the other transitions.
- State S_RESUME: countValue frozen. Priority order:
  - defuseN==0 -> S_DEFUSED
  - waitN==0 -> S_PAUSE, latCnt cleared
  - OneSecPulse: latCnt++; at latCnt==RESUME_SEC -> S_RUN
- State S_LAMP_ON: lampEnable=1, lampTest=1. duty50==0 -> S_LAMP_OFF.
- State S_LAMP_OFF: lampEnable=0. duty50==1 -> blinkCnt++. If BLINKS!=0 and blinkCnt+1==BLINKS -> S_DONE, else -> S_LAMP_ON.
- State S_DONE: lamp off, exploded held. start==0 -> S_ARM, which clears blinkCnt.
- State S_DEFUSED: countValue frozen at its defuse value, lampEnable=1, lampTest=0. start==0 -> S_ARM.
- Inputs ignored after explosion: defuseN and waitN are ignored in S_LAMP_ON, S_LAMP_OFF and S_DONE.
- Mid-operation reset: asynchronous reset at any point returns to the reset state above, with no partial blink.
- Counter widths: latCnt is $clog2(RESUME_SEC+1) bits. blinkCnt is $clog2(BLINKS+1) bits, minimum 1.

Optional Feature:
BOMB_WARN_EN:
- Defined: warn = running && countValue<=WARN_THRESH && countValue!=0 && duty50.
- Undefined: warn is tied 0 and no comparator logic is generated.

Decomposition:
- Package bomb_pkg holds:
  - state enum bomb_state_t, logic[3:0]: S_IDLE, S_ARM, S_RUN, S_PAUSE, S_RESUME, S_LAMP_ON, S_LAMP_OFF, S_DONE, S_DEFUSED
  - helper localparams for the counter widths
- Sub-module bomb_down_counter (parameter CNT_W): ports load, loadVal, en, tick, value, zero. Saturating decrement.

Test Plan:
- Arm/run/explode: loadValue=3, press then release start, 3 pulses -> countValue 3,2,1,0; S_LAMP_ON 1 clock after reaching 0; with BLINKS=2, exactly 2 lampTest high phases, then S_DONE, then exploded=1, lampEnable=0.
- Pause latency: RESUME_SEC=2, waitN low at count=5, release, 1 pulse, then waitN low again -> back in S_PAUSE, count still 5. Release and 2 pulses -> S_RUN and decrement resumes.
- Defuse: defuseN low at count=4 in S_RUN -> S_DEFUSED next clock, defused=1, countValue stays 4 across 10 pulses. start press -> S_ARM reloads.
- Simultaneous events: count=0 with defuseN=0 and waitN=0 in the same clock -> S_LAMP_ON, not S_DEFUSED.
- Zero load: loadValue=0 -> explosion 1 clock after S_RUN entry. Async reset asserted during S_LAMP_ON -> all outputs 0 immediately, S_IDLE.
- BOMB_WARN_EN defined, WARN_THRESH=3, count 4 -> 3 -> warn follows duty50 from count 3 down to 1, and is 0 at count 0 and outside S_RUN.
